sample_decimator: RTL and testbench

SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

---
 rtl/sample_decimator_if.sv | 27 ++
 rtl/sample_decimator.sv | 88 ++++++++
 tb/tb_sample_decimator.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sample_decimator_if.sv
// Sample stream in, decimated FIFO stream out, plus ratio/overflow control.
// The master modport is the bench/upstream side; the slave modport is the decimator.
interface sample_decimator_if #(
  parameter int W     = 10,
  parameter int RW    = 8,
  parameter int LOG2D = 2
);
  logic                 en;
  logic signed [W-1:0]  in;
  logic [RW-1:0]        ratio;
  logic signed [W-1:0]  out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [LOG2D:0]       fill;
  logic                 overflow;
  logic                 ovf_clr;

  modport master (
    output en, in, ratio, out_ready, ovf_clr,
    input  out_data, out_valid, fill, overflow
  );

  modport slave (
    input  en, in, ratio, out_ready, ovf_clr,
    output out_data, out_valid, fill, overflow
  );
endinterface

// File: rtl/sample_decimator.sv
// Keeps one sample in R into a first-word-fall-through FIFO; 1 clk from kept en to out_valid.
// Backpressure: out_ready=0 holds the head; a push into a full FIFO without pop is dropped and sets sticky overflow.
module sample_decimator #(
  parameter int W     = 10,
  parameter int RW    = 8,
  parameter int LOG2D = 2
) (
  input logic             clk,
  input logic             rst,
  sample_decimator_if.slave bus
);
  localparam int DEPTH = 2 ** LOG2D;

  logic [RW-1:0]        phase;
  logic [RW-1:0]        r_q;
  logic                 first_q;
  logic [RW-1:0]        ratio_eff;
  logic [RW-1:0]        r_eff;
  logic [RW:0]          phase_inc;
  logic                 wrap;
  logic                 keep;

  logic signed [W-1:0]  mem [DEPTH];
  logic [LOG2D-1:0]     wptr;
  logic [LOG2D-1:0]     rptr;
  logic [LOG2D:0]       count;
  logic                 ovf_q;
  logic                 full;
  logic                 push;
  logic                 pop;
  logic                 ovf_evt;

  assign ratio_eff = (bus.ratio == '0) ? RW'(1) : bus.ratio;
  // Until the first clock after reset release, the ratio input stands in for the R register.
  assign r_eff     = first_q ? ratio_eff : r_q;
  assign phase_inc = {1'b0, phase} + 1'b1;
  assign wrap      = phase_inc >= {1'b0, r_eff};
  assign keep      = bus.en && (phase == '0);

  assign full      = (count == (LOG2D+1)'(DEPTH));
  assign pop       = (count != '0) && bus.out_ready;
  assign push      = keep && (!full || pop);
  assign ovf_evt   = keep && full && !pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase   <= '0;
      r_q     <= RW'(1);
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (bus.en) begin
        if (wrap) phase <= '0;
        else      phase <= phase_inc[RW-1:0];
      end
      if (first_q || (bus.en && wrap)) r_q <= ratio_eff;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_evt)          ovf_q <= 1'b1;
      else if (bus.ovf_clr) ovf_q <= 1'b0;
    end
  end

  // Storage needs no reset: emptiness is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= bus.in;
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = (count != '0) ? mem[rptr] : '0;
  assign bus.fill      = count;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_sample_decimator.sv
// Directed and random stimulus for sample_decimator against a queue-based reference model.
module tb_sample_decimator;
  localparam int W     = 10;
  localparam int RW    = 8;
  localparam int LOG2D = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sample_decimator_if #(.W(W), .RW(RW), .LOG2D(LOG2D)) bus ();
  sample_decimator #(.W(W), .RW(RW), .LOG2D(LOG2D)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] dg[$];
  int           m_idx;
  int           m_r;
  bit           m_ovf;
  int           ex[$];

  function automatic int eff(int r);
    return (r == 0) ? 1 : r;
  endfunction

  function automatic logic [31:0] z(logic [W-1:0] v);
    return {{(32-W){1'b0}}, v};
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [W-1:0] ed;
    ed = (mq.size() != 0) ? mq[0] : '0;
    check("out_valid", {31'b0, bus.out_valid}, (mq.size() != 0) ? 32'd1 : 32'd0);
    check("fill", {{(31-LOG2D){1'b0}}, bus.fill}, mq.size());
    check("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
    check("out_data", z(bus.out_data), z(ed));
  endtask

  // One clock: check current outputs, drive inputs, advance the model across the coming edge.
  task automatic cyc(bit e, int d, bit rdy, bit clr = 1'b0);
    bit pop;
    bit ovf_new;
    check_state();
    if (bus.out_valid && rdy) dg.push_back(bus.out_data);
    bus.en = e; bus.in = W'(d); bus.out_ready = rdy; bus.ovf_clr = clr;
    ovf_new = 1'b0;
    pop = (mq.size() != 0) && rdy;
    if (pop) void'(mq.pop_front());
    if (e) begin
      if (m_idx == 0) begin
        if (mq.size() < DEPTH) mq.push_back(W'(d));
        else ovf_new = 1'b1;
      end
      m_idx++;
      if (m_idx >= m_r) begin
        m_idx = 0;
        m_r   = eff(int'(bus.ratio));
      end
    end
    m_ovf = ovf_new ? 1'b1 : (clr ? 1'b0 : m_ovf);
    @(negedge clk);
  endtask

  task automatic do_reset(int r);
    rst = 1'b0;
    bus.en = 1'b0; bus.in = '0; bus.out_ready = 1'b0; bus.ovf_clr = 1'b0;
    bus.ratio = RW'(r);
    mq.delete(); dg.delete();
    m_ovf = 1'b0; m_idx = 0;
    @(negedge clk);
    check_state();
    @(negedge clk);
    rst = 1'b1;
    m_r = eff(r);
  endtask

  task automatic check_list(string tag);
    check({tag, "_count"}, dg.size(), ex.size());
    for (int i = 0; i < dg.size() && i < ex.size(); i++)
      check(tag, z(dg[i]), z(W'(ex[i])));
  endtask

  initial begin
    // Decimate by 3: 1..9 -> 1,4,7
    do_reset(3);
    for (int i = 1; i <= 9; i++) cyc(1'b1, i, 1'b1);
    cyc(1'b0, 0, 1'b1);
    ex = '{1, 4, 7};
    check_list("dec3");

    // Ratio 0 and ratio 1 pass everything
    do_reset(0);
    cyc(1'b1, -5, 1'b1); cyc(1'b1, 7, 1'b1); cyc(1'b1, -512, 1'b1); cyc(1'b0, 0, 1'b1);
    ex = '{-5, 7, -512};
    check_list("ratio0");
    dg.delete();
    bus.ratio = RW'(1);
    cyc(1'b1, -5, 1'b1); cyc(1'b1, 7, 1'b1); cyc(1'b1, -512, 1'b1); cyc(1'b0, 0, 1'b1);
    check_list("ratio1");

    // Backpressure and overflow, then set-wins over clear
    do_reset(1);
    for (int i = 10; i <= 15; i++) cyc(1'b1, i, 1'b0);
    check("ovf_fill", {{(31-LOG2D){1'b0}}, bus.fill}, 32'd4);
    check("ovf_head", z(bus.out_data), 32'd10);
    check("ovf_flag", {31'b0, bus.overflow}, 32'd1);
    cyc(1'b1, 99, 1'b0, 1'b1);
    check("ovf_setwins", {31'b0, bus.overflow}, 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1);
    ex = '{10, 11, 12, 13};
    check_list("ovf_drain");
    cyc(1'b0, 0, 1'b1, 1'b1);
    check("ovf_clr", {31'b0, bus.overflow}, 32'd0);

    // Full FIFO with simultaneous push and pop
    do_reset(1);
    for (int i = 20; i <= 23; i++) cyc(1'b1, i, 1'b0);
    cyc(1'b1, 24, 1'b1);
    check("fullpp_fill", {{(31-LOG2D){1'b0}}, bus.fill}, 32'd4);
    check("fullpp_ovf", {31'b0, bus.overflow}, 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 0, 1'b1);
    ex = '{20, 21, 22, 23, 24};
    check_list("fullpp");

    // Mid-group ratio change takes effect at next group
    do_reset(4);
    cyc(1'b1, 1, 1'b1);
    bus.ratio = RW'(2);
    for (int i = 2; i <= 10; i++) cyc(1'b1, i, 1'b1);
    cyc(1'b0, 0, 1'b1);
    ex = '{1, 5, 7, 9};
    check_list("midchg");

    // Asynchronous reset between edges
    do_reset(1);
    for (int i = 30; i <= 34; i++) cyc(1'b1, i, 1'b0);
    cyc(1'b0, 0, 1'b1);
    check("ar_pre_fill", {{(31-LOG2D){1'b0}}, bus.fill}, 32'd3);
    #2 rst = 1'b0;
    #1;
    check("ar_valid", {31'b0, bus.out_valid}, 32'd0);
    check("ar_fill", {{(31-LOG2D){1'b0}}, bus.fill}, 32'd0);
    check("ar_ovf", {31'b0, bus.overflow}, 32'd0);
    check("ar_data", z(bus.out_data), 32'd0);
    bus.ratio = RW'(3);
    bus.en = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mq.delete(); dg.delete(); m_ovf = 1'b0; m_idx = 0; m_r = 3;
    cyc(1'b1, 77, 1'b1); cyc(1'b1, 78, 1'b1); cyc(1'b0, 0, 1'b1);
    ex = '{77};
    check_list("ar_first");

    // Random traffic against the model
    do_reset(int'($urandom_range(0, 5)));
    for (int i = 0; i < 600; i++) begin
      bit rdy;
      if ($urandom_range(0, 19) == 0) bus.ratio = RW'($urandom_range(0, 5));
      rdy = ((i % 100) < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 1023)) - 512, rdy,
          $urandom_range(0, 15) == 0);
    end
    check_state();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
